// File: rtl/mult_seq.sv
// mult_seq: sequential shift-add multiplier, one multiplier bit per clock, signed or unsigned.
module mult_seq #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic                 sign,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, ma_q, ma_d, z_q, z_d, sum;
  logic [WIDTH-1:0] mb_q, mb_d, abs_a, abs_b;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, accept, last;
  assign accept = ena && state_q != CALC;
  assign last   = cnt_q == CNT_W'(WIDTH - 1);
  assign abs_a  = (sign && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (sign && b[WIDTH-1]) ? -b : b;
  // multiplicand shifts left and multiplier right, so bit i always lands at mb_q[0]
  assign sum    = acc_q + (mb_q[0] ? ma_q : '0);
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    if (accept) begin
      ma_d    = {{WIDTH{1'b0}}, abs_a};
      mb_d    = abs_b;
      neg_d   = sign && (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d   = '0;
      cnt_d   = '0;
      state_d = (a == '0 || b == '0) ? DONE : CALC;
      z_d     = (a == '0 || b == '0) ? '0 : z_q;
    end else if (state_q == CALC) begin
      acc_d = sum;
      ma_d  = ma_q << 1;
      mb_d  = mb_q >> 1;
      cnt_d = cnt_q + 1'b1;
      state_d = last ? DONE : CALC;
      z_d     = last ? (neg_q ? -sum : sum) : z_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end
  assign busy = state_q == CALC;
  assign done = state_q == DONE;
  assign z    = z_q;
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed scoreboard bench for the sequential multiplier at WIDTH=32.
module tb_mult_seq;
  logic clk = 1'b0, reset = 1'b1, ena = 1'b0, sign = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [63:0] z;
  logic [63:0] exp_q[$];
  int checks = 0, errors = 0;

  mult_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ena(ena), .sign(sign),
    .a(a), .b(b), .busy(busy), .done(done), .z(z)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
    sign = s; a = x; b = y; ena = 1'b1;
    exp_q.push_back(model(s, x, y));
    tick();
    ena = 1'b0;
  endtask

  // waits for done starting at cycle n0 after accept; busy must be high on every cycle before it
  task automatic collect(input string tag, input int lat, input int n0);
    int n = n0;
    int bad = 0;
    logic [63:0] e = '0;
    while (!done && n <= lat + 3) begin
      if (busy !== 1'b1) bad++;
      tick();
      n++;
    end
    chk({tag, "_busy"}, 64'(bad), 64'd0);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_busydone"}, {63'b0, busy}, 64'd0);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk({tag, "_z"}, z, e);
  endtask

  initial begin
    logic [31:0] rx, ry;
    logic rs;
    reset = 1'b1;
    tick();
    chk("rst1_z", z, 64'd0);
    chk("rst1_bd", {62'b0, busy, done}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_z", z, 64'd0);
    chk("idle_bd", {62'b0, busy, done}, 64'd0);

    issue(1'b1, 32'hFFFFFFFD, 32'd7);
    collect("neg21", 33, 1);
    tick();
    chk("pulse", {63'b0, done}, 64'd0);

    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    collect("umax", 33, 1);
    issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    collect("smin1", 33, 1);
    issue(1'b1, 32'h80000000, 32'h80000000);
    collect("smin", 33, 1);
    chk("smin_const", z, 64'h40000000_00000000);
    tick();

    issue(1'b1, 32'd0, 32'h12345678);
    collect("zero", 1, 1);
    tick();
    chk("zero_pulse", {63'b0, done}, 64'd0);

    issue(1'b1, 32'd6, 32'd7);
    a = 32'd9; ena = 1'b1;
    tick();
    ena = 1'b0;
    collect("ignore", 33, 2);
    chk("ignore_const", z, 64'd42);
    issue(1'b0, 32'd5, 32'd5);
    collect("b2b", 33, 1);
    chk("b2b_const", z, 64'd25);

    for (int k = 0; k < 4; k++) begin
      rs = 1'($urandom_range(0, 1));
      rx = $urandom;
      ry = (k == 2) ? 32'd0 : $urandom;
      issue(rs, rx, ry);
      collect("rand", (rx == 0 || ry == 0) ? 1 : 33, 1);
    end

    tick();
    issue(1'b0, 32'd1000, 32'd1000);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_z", z, 64'd0);
    chk("abort_bd", {62'b0, busy, done}, 64'd0);
    begin
      int bad = 0;
      for (int k = 0; k < 40; k++) begin
        if (done !== 1'b0 || busy !== 1'b0) bad++;
        tick();
      end
      chk("abort_quiet", 64'(bad), 64'd0);
    end
    issue(1'b0, 32'd2, 32'd3);
    collect("post_abort", 33, 1);
    chk("post_abort_const", z, 64'd6);
    tick();

    reset = 1'b1; ena = 1'b1; sign = 1'b0; a = 32'd2; b = 32'd2;
    tick();
    reset = 1'b0; ena = 1'b0;
    begin
      int bad = 0;
      for (int k = 0; k < 5; k++) begin
        if (done !== 1'b0 || busy !== 1'b0) bad++;
        tick();
      end
      chk("rst_wins", 64'(bad), 64'd0);
    end
    chk("rst_wins_z", z, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised, multi-cycle, shift-add integer multiplier for the single-cycle CPU's MULT/MULTU path. It computes the full 2*WIDTH-bit product of two WIDTH-bit operands, in signed or unsigned mode, one multiplier bit per clock. It uses a start/busy/done handshake so the control unit can stall while the product forms. It sits beside the ALU, and its result feeds the HI/LO register pair.

## Interface
- WIDTH, 32, operand width in bits (≥2); product is 2*WIDTH bits
- CNT_W, $clog2(WIDTH)+1, bit counter width (derived; not overridden)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- ena  in  1  start request; sampled only when the block can accept (IDLE or DONE)
- sign  in  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with ena
- a  in  WIDTH  multiplicand; sampled with ena
- b  in  WIDTH  multiplier; sampled with ena
- busy  out  1  high while a product is being formed
- done  out  1  one-cycle pulse; z valid from this cycle on
- z  out  2*WIDTH  product; holds until the next done

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE, z=0, busy=0, done=0, clears accumulator, counter, operand registers and neg flag.
- Accept: ena=1 in IDLE or DONE. On that edge:
  - Latch mag_a = (sign & a[MSB]) ? -a : a (WIDTH bits, unsigned).
  - Latch mag_b likewise.
  - Latch neg = sign & (a[MSB] ^ b[MSB]).
  - Clear acc (2*WIDTH bits) and counter.
- Zero early-out: if a==0 or b==0 at accept, go directly to DONE; z=0 next cycle, skipping CALC.
- CALC, counter i = 0..WIDTH-1, one step per cycle:
  - If mag_b[i], acc += {WIDTH'b0, mag_a} << i.
  - Increment i.
  - After step WIDTH-1, go to DONE.
- Entering DONE: z <= neg ? -acc : acc (two's complement, 2*WIDTH bits). done=1 for that single cycle.
- DONE → CALC (or DONE via early-out) if ena; otherwise → IDLE. Back-to-back issue is allowed.
- ena, sign, a, b are ignored while in CALC; operands need not be held after accept.
- Magnitude width rule: -2^(WIDTH-1) maps to unsigned 2^(WIDTH-1), so no overflow occurs. Signed (-2^(WIDTH-1))² = 2^(2*WIDTH-2) is exact.
- Unsigned mode never negates, regardless of operand MSBs.

## Timing
- Accept on edge 0. Normal path: busy=1 cycles 1..WIDTH; done=1 and z valid in cycle WIDTH+1. Latency is WIDTH+1 cycles (33 at WIDTH=32).
- Zero path: busy stays 0; done=1 and z=0 in cycle 1.
- busy and done are never both high. busy=0 in IDLE and DONE.
- Issue rate: a new accept in the done cycle yields the next done WIDTH+1 cycles later.
- reset during CALC: next cycle is IDLE with z=0, busy=0, done=0. No done pulse is produced for the aborted operation.
- reset and ena high together: reset wins; the request is dropped.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then idle: reset high 2 cycles, ena=0 → z=0, busy=0, done=0 throughout.
- Signed: sign=1, a=-3 (0xFFFFFFFD), b=7, pulse ena → busy for cycles 1..32, done in cycle 33, z=0xFFFFFFFF_FFFFFFEB (-21).
- Unsigned vs signed: a=b=0xFFFFFFFF.
  - sign=0 → z=0xFFFFFFFE_00000001.
  - sign=1 → z=1.
  - sign=1, a=b=0x80000000 → z=0x40000000_00000000.
- Zero early-out: sign=1, a=0, b=0x12345678 → done in cycle 1, busy never high, z=0. Previous nonzero z is replaced.
- Back-to-back and ignore-while-busy:
  - Issue 6×7, then toggle ena with a=9 during CALC → done gives 42; the CALC-time ena is ignored.
  - Assert ena with 5×5 in the done cycle → next done 33 cycles later with z=25.
- Reset mid-operation: start 1000×1000, assert reset at cycle 10 → idle next cycle, z=0, no done pulse. A subsequent 2×3 yields z=6 after 33 cycles.
